// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit AND/OR unit with a
// single registered response slot that drains and refills in the same cycle.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_r0_valid,
  output logic             o_r0_ready,
  input  logic [WIDTH-1:0] i_r0_a,
  input  logic [WIDTH-1:0] i_r0_b,
  input  logic             i_r0_op,
  input  logic [TAG_W-1:0] i_r0_tag,
  input  logic             i_r1_valid,
  output logic             o_r1_ready,
  input  logic [WIDTH-1:0] i_r1_a,
  input  logic [WIDTH-1:0] i_r1_b,
  input  logic             i_r1_op,
  input  logic [TAG_W-1:0] i_r1_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_src,
  output logic [TAG_W-1:0] o_rsp_tag
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t           r_state;
  logic             r_rr_ptr;
  logic [WIDTH-1:0] r_data;
  logic             r_src;
  logic [TAG_W-1:0] r_tag;

  logic             w_can_accept;
  logic             w_any_vld;
  logic             w_gnt;
  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_op;
  logic [TAG_W-1:0] w_tag;
  logic [WIDTH-1:0] w_result;

  // A lone requester always wins; the pointer only breaks ties.
  assign w_can_accept = (r_state == S_EMPTY) | i_rsp_ready;
  assign w_any_vld    = i_r0_valid | i_r1_valid;
  assign w_gnt        = (i_r0_valid & i_r1_valid) ? r_rr_ptr : i_r1_valid;

  assign o_r0_ready = i_reset_n & w_can_accept & w_any_vld & (w_gnt == 1'b0);
  assign o_r1_ready = i_reset_n & w_can_accept & w_any_vld & (w_gnt == 1'b1);
  assign w_accept   = (i_r0_valid & o_r0_ready) | (i_r1_valid & o_r1_ready);

  assign w_a      = w_gnt ? i_r1_a   : i_r0_a;
  assign w_b      = w_gnt ? i_r1_b   : i_r0_b;
  assign w_op     = w_gnt ? i_r1_op  : i_r0_op;
  assign w_tag    = w_gnt ? i_r1_tag : i_r0_tag;
  assign w_result = w_op ? (w_a | w_b) : (w_a & w_b);

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state  <= S_EMPTY;
      r_rr_ptr <= 1'b0;
      r_data   <= '0;
      r_src    <= 1'b0;
      r_tag    <= '0;
    end else begin
      if (w_accept) begin
        r_data   <= w_result;
        r_src    <= w_gnt;
        r_tag    <= w_tag;
        r_rr_ptr <= ~w_gnt;
      end
      case (r_state)
        S_EMPTY: if (w_accept) r_state <= S_FULL;
        S_FULL:  if (i_rsp_ready && !w_accept) r_state <= S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign o_rsp_valid = (r_state == S_FULL);
  assign o_rsp_data  = r_data;
  assign o_rsp_src   = r_src;
  assign o_rsp_tag   = r_tag;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed-vector bench for logic_unit_arbiter: reset, AND/OR, alternation,
// backpressure with same-cycle drain/refill, and reset during a stall.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r0_op;
  logic [31:0] r0_a, r0_b;
  logic [3:0]  r0_tag;
  logic        r1_valid, r1_ready, r1_op;
  logic [31:0] r1_a, r1_b;
  logic [3:0]  r1_tag;
  logic        rsp_valid, rsp_ready, rsp_src;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(32), .TAG_W(4)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_r0_valid(r0_valid), .o_r0_ready(r0_ready), .i_r0_a(r0_a), .i_r0_b(r0_b),
    .i_r0_op(r0_op), .i_r0_tag(r0_tag),
    .i_r1_valid(r1_valid), .o_r1_ready(r1_ready), .i_r1_a(r1_a), .i_r1_b(r1_b),
    .i_r1_op(r1_op), .i_r1_tag(r1_tag),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_src(rsp_src), .o_rsp_tag(rsp_tag)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string nm, input logic e0, input logic e1);
    @(negedge clk);
    chk({nm, ".r0_ready"}, {31'd0, r0_ready}, {31'd0, e0});
    chk({nm, ".r1_ready"}, {31'd0, r1_ready}, {31'd0, e1});
  endtask

  task automatic chk_rsp(input string nm, input logic v, input logic [31:0] d,
                         input logic s, input logic [3:0] t);
    @(posedge clk); #1;
    chk({nm, ".valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({nm, ".data"},  rsp_data,           d);
    chk({nm, ".src"},   {31'd0, rsp_src},   {31'd0, s});
    chk({nm, ".tag"},   {28'd0, rsp_tag},   {28'd0, t});
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 32'hF0F01234; r0_b = 32'h0FF0FFFF; r0_op = 1'b0; r0_tag = 4'd3;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = 1'b0; r1_tag = '0;

    // reset held 3 cycles with r0 requesting
    for (int i = 0; i < 3; i++) begin
      chk_rdy("reset", 1'b0, 1'b0);
      chk_rsp("reset", 1'b0, 32'h0, 1'b0, 4'd0);
    end
    rst_n = 1'b1;

    // first cycle after release: r0 accepted, AND result next cycle
    chk_rdy("and", 1'b1, 1'b0);
    chk_rsp("and", 1'b1, 32'h00F01234, 1'b0, 4'd3);
    r0_valid = 1'b0;

    r1_valid = 1'b1; r1_a = 32'h80000000; r1_b = 32'h00000001; r1_op = 1'b1; r1_tag = 4'd9;
    chk_rdy("or", 1'b0, 1'b1);
    chk_rsp("or", 1'b1, 32'h80000001, 1'b1, 4'd9);
    r1_valid = 1'b0;
    chk_rsp("idle", 1'b0, 32'h80000001, 1'b1, 4'd9);

    // contention: strict alternation starting at r0, no bubbles
    r0_valid = 1'b1; r0_a = 32'hFFFF0000; r0_b = 32'h0F0F0F0F; r0_op = 1'b0; r0_tag = 4'd1;
    r1_valid = 1'b1; r1_a = 32'h00000011; r1_b = 32'h00001100; r1_op = 1'b1; r1_tag = 4'd2;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        chk_rdy("rr", 1'b1, 1'b0);
        chk_rsp("rr", 1'b1, 32'h0F0F0000, 1'b0, 4'd1);
      end else begin
        chk_rdy("rr", 1'b0, 1'b1);
        chk_rsp("rr", 1'b1, 32'h00001111, 1'b1, 4'd2);
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk_rsp("rr_drain", 1'b0, 32'h00001111, 1'b1, 4'd2);

    // backpressure: fill, then stall 4 cycles with both requesting
    r0_valid = 1'b1; r0_a = 32'h0000FFFF; r0_b = 32'h12340000; r0_op = 1'b1; r0_tag = 4'd5;
    chk_rdy("bp_fill", 1'b1, 1'b0);
    chk_rsp("bp_fill", 1'b1, 32'h1234FFFF, 1'b0, 4'd5);
    rsp_ready = 1'b0;
    r0_a = 32'hAAAAAAAA; r0_b = 32'h55555555; r0_op = 1'b0; r0_tag = 4'd6;
    r1_valid = 1'b1; r1_a = 32'hAAAAAAAA; r1_b = 32'h55555555; r1_op = 1'b1; r1_tag = 4'd7;
    for (int i = 0; i < 4; i++) begin
      chk_rdy("stall", 1'b0, 1'b0);
      chk_rsp("stall", 1'b1, 32'h1234FFFF, 1'b0, 4'd5);
    end
    rsp_ready = 1'b1;
    chk_rdy("bp_release", 1'b0, 1'b1);
    chk_rsp("bp_release", 1'b1, 32'hFFFFFFFF, 1'b1, 4'd7);
    r1_valid = 1'b0;
    chk_rdy("bp_next", 1'b1, 1'b0);
    chk_rsp("bp_next", 1'b1, 32'h00000000, 1'b0, 4'd6);

    // reset mid-stall: pointer now favours r1, reset must restore r0
    r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b0; r0_tag = 4'd4;
    r0_a = 32'hC3C3C3C3; r0_b = 32'hFF00FF00; r0_op = 1'b0;
    rst_n = 1'b0;
    chk_rdy("rst_stall", 1'b0, 1'b0);
    chk_rsp("rst_stall", 1'b0, 32'h0, 1'b0, 4'd0);
    rst_n = 1'b1; rsp_ready = 1'b1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    chk_rsp("post_rst", 1'b1, 32'hC300C300, 1'b0, 4'd4);
    r0_valid = 1'b0; r1_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
